dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate L1 data cache controller between the RISC-V core's load/store port and Data_Memory.
- Acts as the initiator on the Data_Memory interface: drives address, write data and write enable, and samples read data.
- Presents a zero-wait-state read-hit port to the core and stalls the core on misses and writes.
- Data_Memory semantics: combinational read, write on CLK rising edge when WE=1, word-addressed.

Parameters:
- AW, 10, word-address width (core and memory side).
- DW, 32, data width.
- LINES, 32, number of cache lines.
- WPL, 4, words per line.
- MEM_LAT, 2, cycles each memory word access is held (minimum 1).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- A  in  AW  core word address.
- WD  in  DW  core write data.
- RE  in  1  core read request.
- WE  in  1  core write request.
- RD  out  DW  core read data.
- STALL  out  1  core must hold request and pipeline.
- MEM_A  out  AW  memory address.
- MEM_WD  out  DW  memory write data.
- MEM_WE  out  1  memory write enable.
- MEM_RD  in  DW  memory read data.
- HIT_CNT  out  16  read-hit counter, saturating.
- MISS_CNT  out  16  read-miss counter, saturating.

Behaviour:
- Address split (defaults): offset = A[1:0], index = A[6:2], tag = A[9:7].
- Per-line state: valid bit, tag register, WPL data words.
- Reset (async): FSM to IDLE; all valid bits cleared; MEM_WE=0; MEM_A=0; MEM_WD=0; word and latency counters 0; HIT_CNT=MISS_CNT=0. Data array is not reset.
- States: IDLE, REFILL, WRITE.
- Hit = valid[index] && tag match.
- IDLE, RE && !WE && hit: RD = line word combinationally, STALL=0, HIT_CNT+1.
- IDLE, RE && !WE && miss: STALL=1 combinationally, MISS_CNT+1, go REFILL with wcnt=0, lat=0.
- REFILL:
  - MEM_A = {tag, index, wcnt}; STALL=1.
  - When lat == MEM_LAT-1: capture MEM_RD into word wcnt, lat=0, wcnt+1.
  - After word WPL-1 is captured: set tag and valid, go IDLE.
  - Miss penalty is WPL*MEM_LAT stall cycles; the held request then hits and is counted as a hit as well.
- IDLE, WE (WE has priority over simultaneous RE):
  - STALL=1; go WRITE.
  - On that edge, register MEM_A=A and MEM_WD=WD, and set MEM_WE=1.
  - On a write hit, update the cached word on the same edge. A write miss does not allocate.
- WRITE:
  - MEM_WE is high only in the first WRITE cycle (single pulse).
  - Remain in WRITE for MEM_LAT cycles with STALL=1, then return to IDLE and deassert STALL.
- Neither RE nor WE: STALL=0. RD = 0 whenever not delivering a hit.
- Counters saturate at 16'hFFFF and do not wrap.
- Reset mid-REFILL: partial line stays invalid; a re-issued read misses again.
- Reset mid-WRITE: MEM_WE drops immediately.
- Core must not change A/WD/RE/WE while STALL=1; behaviour is otherwise undefined.

Decomposition:
- Package dcache_pkg holds:
  - state encoding (IDLE/REFILL/WRITE);
  - derived widths OFF_W = log2(WPL), IDX_W = log2(LINES), TAG_W = AW - IDX_W - OFF_W;
  - the field-extract functions.
- One sub-module, dcache_array: valid/tag/data storage, with async valid clear, a line-word write port and a combinational hit/read port.
- dcache_ctrl holds the FSM, counters and memory-side registers.

Test Plan:
- Memory preload: word i = 255-i.
- Reset, then RE to A=0x004 → STALL high for 8 cycles (MEM_LAT=2); MEM_A steps 0x004,0x005,0x006,0x007; then RD=0x000000FB, STALL=0; MISS_CNT=1, HIT_CNT=1.
- Following RE A=0x005 → hit in same cycle, RD=0x000000FA, STALL=0, HIT_CNT=2, MEM_WE never asserted.
- WE A=0x005, WD=0xDEADBEEF → exactly one MEM_WE pulse with MEM_A=0x005, MEM_WD=0xDEADBEEF; STALL for 2 cycles; then RE 0x005 hits with RD=0xDEADBEEF.
- WE to uncached A=0x200, WD=0x12345678 → one memory write pulse; subsequent RE 0x200 misses (MISS_CNT increments); refill returns 0x12345678.
- RE A=0x084 after 0x004 is cached (same index 1, tag 1 vs 0) → refill MEM_A 0x084..0x087 and RD=0x0000007B; RE 0x004 then misses again.
- Assert RST after 3 REFILL cycles → STALL, MEM_WE, counters all 0; re-issued RE to the same address performs a full refill.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: geometry, FSM encoding and address field helpers for the L1 data cache.
package dcache_pkg;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LINES = 32;
    localparam int WPL = 4;
    localparam int OFF_W = $clog2(WPL);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = AW - IDX_W - OFF_W;
    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;
    function automatic logic [OFF_W-1:0] addr_off(input logic [AW-1:0] a);
        return a[OFF_W-1:0];
    endfunction
    function automatic logic [IDX_W-1:0] addr_idx(input logic [AW-1:0] a);
        return a[OFF_W +: IDX_W];
    endfunction
    function automatic logic [TAG_W-1:0] addr_tag(input logic [AW-1:0] a);
        return a[AW-1 -: TAG_W];
    endfunction
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return c + 16'(c != 16'hFFFF);
    endfunction
endpackage

// File: rtl/dcache_if.sv
// dcache_if: core load/store port plus Data_Memory bus seen by the cache controller.
interface dcache_if;
    import dcache_pkg::*;
    logic [AW-1:0] A;
    logic [DW-1:0] WD;
    logic RE;
    logic WE;
    logic [DW-1:0] RD;
    logic STALL;
    logic [AW-1:0] MEM_A;
    logic [DW-1:0] MEM_WD;
    logic MEM_WE;
    logic [DW-1:0] MEM_RD;
    logic [15:0] HIT_CNT;
    logic [15:0] MISS_CNT;
    modport slave(input A, WD, RE, WE, MEM_RD,
                  output RD, STALL, MEM_A, MEM_WD, MEM_WE, HIT_CNT, MISS_CNT);
    modport master(output A, WD, RE, WE, MEM_RD,
                   input RD, STALL, MEM_A, MEM_WD, MEM_WE, HIT_CNT, MISS_CNT);
endinterface

// File: rtl/dcache_array.sv
// dcache_array: valid/tag/data storage, lookup and word write share the core's index.
module dcache_array
    import dcache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [OFF_W-1:0] off_i,
    output logic             hit_o,
    output logic [DW-1:0]    data_o,
    input  logic             we_i,
    input  logic [OFF_W-1:0] w_off_i,
    input  logic [DW-1:0]    w_data_i,
    input  logic             set_i
);
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [LINES];
    logic [DW-1:0] data_q [LINES][WPL];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= '0;
        else if (set_i) valid_q[idx_i] <= 1'b1;
    end
    // Tags and data are deliberately left unreset; the valid bits gate them.
    always_ff @(posedge clk) begin
        if (set_i) tag_q[idx_i] <= tag_i;
        if (we_i) data_q[idx_i][w_off_i] <= w_data_i;
    end
    assign hit_o = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
    assign data_o = data_q[idx_i][off_i];
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through no-write-allocate L1 data cache controller.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input logic CLK,
    input logic RST,
    dcache_if.slave bus
);
    localparam int LAT_W = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
    state_t state_q, state_d;
    logic [OFF_W-1:0] wcnt_q, wcnt_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [AW-1:0] mem_a_q, mem_a_d;
    logic [DW-1:0] mem_wd_q, mem_wd_d;
    logic mem_we_q, mem_we_d;
    logic done_q, done_d;
    logic [15:0] hit_q, hit_d, miss_q, miss_d;
    logic hit, arr_we, arr_set;
    logic [OFF_W-1:0] arr_off;
    logic [DW-1:0] arr_wdata, line_word;
    dcache_array u_array (
        .clk(CLK), .rst(RST),
        .idx_i(addr_idx(bus.A)), .tag_i(addr_tag(bus.A)), .off_i(addr_off(bus.A)),
        .hit_o(hit), .data_o(line_word),
        .we_i(arr_we), .w_off_i(arr_off), .w_data_i(arr_wdata), .set_i(arr_set)
    );
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            wcnt_q <= '0;
            lat_q <= '0;
            mem_a_q <= '0;
            mem_wd_q <= '0;
            mem_we_q <= 1'b0;
            done_q <= 1'b0;
            hit_q <= '0;
            miss_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q <= wcnt_d;
            lat_q <= lat_d;
            mem_a_q <= mem_a_d;
            mem_wd_q <= mem_wd_d;
            mem_we_q <= mem_we_d;
            done_q <= done_d;
            hit_q <= hit_d;
            miss_q <= miss_d;
        end
    end
    // done_q marks the cycle after a write, letting the held WE retire unstalled.
    always_comb begin
        state_d = state_q;
        wcnt_d = wcnt_q;
        lat_d = lat_q;
        mem_a_d = mem_a_q;
        mem_wd_d = mem_wd_q;
        mem_we_d = 1'b0;
        done_d = 1'b0;
        hit_d = hit_q;
        miss_d = miss_q;
        arr_we = 1'b0;
        arr_set = 1'b0;
        arr_off = addr_off(bus.A);
        arr_wdata = bus.WD;
        bus.RD = '0;
        bus.STALL = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.WE && !done_q) begin
                    bus.STALL = 1'b1;
                    state_d = WRITE;
                    lat_d = '0;
                    mem_a_d = bus.A;
                    mem_wd_d = bus.WD;
                    mem_we_d = 1'b1;
                    arr_we = hit;
                end else if (bus.RE && !bus.WE) begin
                    bus.RD = hit ? line_word : '0;
                    bus.STALL = !hit;
                    hit_d = hit ? sat_inc(hit_q) : hit_q;
                    miss_d = hit ? miss_q : sat_inc(miss_q);
                    state_d = hit ? IDLE : REFILL;
                    wcnt_d = hit ? wcnt_q : '0;
                    lat_d = hit ? lat_q : '0;
                end
            end
            REFILL: begin
                bus.STALL = 1'b1;
                lat_d = lat_q + 1'b1;
                if (lat_q == LAT_LAST) begin
                    lat_d = '0;
                    wcnt_d = wcnt_q + 1'b1;
                    arr_we = 1'b1;
                    arr_off = wcnt_q;
                    arr_wdata = bus.MEM_RD;
                    arr_set = wcnt_q == OFF_W'(WPL - 1);
                    state_d = arr_set ? IDLE : REFILL;
                end
            end
            WRITE: begin
                bus.STALL = 1'b1;
                lat_d = lat_q + 1'b1;
                if (lat_q == LAT_LAST) begin
                    lat_d = '0;
                    done_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.MEM_A = state_q == REFILL ? {addr_tag(bus.A), addr_idx(bus.A), wcnt_q} : mem_a_q;
    assign bus.MEM_WD = mem_wd_q;
    assign bus.MEM_WE = mem_we_q;
    assign bus.HIT_CNT = hit_q;
    assign bus.MISS_CNT = miss_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed table, reset corner cases and random traffic against a
// line-level cache model backed by a sparse reference memory.
module tb_dcache_ctrl;
    import dcache_pkg::*;
    localparam int LAT = 2;
    localparam int REFILL_CYC = WPL * LAT;
    logic CLK = 1'b0;
    logic RST;
    dcache_if bus();
    dcache_ctrl #(.MEM_LAT(LAT)) u_dut (.CLK(CLK), .RST(RST), .bus(bus));
    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] init_word(input int a);
        return DW'(255 - a);
    endfunction

    logic [DW-1:0] mem [1<<AW];
    bit wr [1<<AW];
    int pulse_total = 0;
    logic [AW-1:0] pulse_a;
    logic [DW-1:0] pulse_wd;
    assign bus.MEM_RD = wr[bus.MEM_A] ? mem[bus.MEM_A] : init_word(int'(bus.MEM_A));
    always @(posedge CLK) begin
        if (bus.MEM_WE) begin
            mem[bus.MEM_A] <= bus.MEM_WD;
            wr[bus.MEM_A] <= 1'b1;
            pulse_total <= pulse_total + 1;
            pulse_a <= bus.MEM_A;
            pulse_wd <= bus.MEM_WD;
        end
    end

    logic [DW-1:0] ref_mem [int];
    bit mv [LINES];
    int mtag [LINES];
    int m_hits = 0;
    int m_miss = 0;
    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (mv[i]) mv[i] = 1'b0;
        m_hits = 0;
        m_miss = 0;
    endtask

    // One core access from a negedge: checks stall length, refill walk, data, pulses, counters.
    task automatic do_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input string nm, output logic [DW-1:0] rd_o, output bit hit_o);
        int idx = (int'(a) / WPL) % LINES;
        int tg = int'(a) / (WPL * LINES);
        int base = int'(a) - int'(a) % WPL;
        bit exp_hit = !we && mv[idx] && mtag[idx] == tg;
        int p0 = pulse_total;
        int n = 0;
        logic [AW-1:0] trace [$];
        bus.A = a;
        bus.WD = wd;
        bus.RE = !we;
        bus.WE = we;
        #1;
        hit_o = !bus.STALL;
        check({nm, " stall0"}, bus.STALL, !exp_hit);
        while (bus.STALL && n < 100) begin
            @(negedge CLK);
            #1;
            if (bus.STALL) begin
                n++;
                trace.push_back(bus.MEM_A);
            end
        end
        check({nm, " stall_cycles"}, n, we ? LAT : exp_hit ? 0 : REFILL_CYC);
        rd_o = bus.RD;
        if (!we) begin
            check({nm, " rd"}, bus.RD, ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(int'(a)));
            if (!exp_hit && trace.size() == REFILL_CYC)
                foreach (trace[k]) check({nm, " refill_addr"}, trace[k], base + k / LAT);
        end
        @(posedge CLK);
        if (we) ref_mem[int'(a)] = wd;
        else begin
            m_hits++;
            if (!exp_hit) begin
                m_miss++;
                mv[idx] = 1'b1;
                mtag[idx] = tg;
            end
        end
        @(negedge CLK);
        bus.RE = 1'b0;
        bus.WE = 1'b0;
        #1;
        check({nm, " mem_we_pulses"}, pulse_total - p0, we);
        if (we) begin
            check({nm, " pulse_addr"}, pulse_a, a);
            check({nm, " pulse_data"}, pulse_wd, wd);
        end
        check({nm, " hit_cnt"}, bus.HIT_CNT, m_hits);
        check({nm, " miss_cnt"}, bus.MISS_CNT, m_miss);
        check({nm, " idle_stall"}, bus.STALL, 0);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, " stall"}, bus.STALL, 0);
        check({nm, " mem_we"}, bus.MEM_WE, 0);
        check({nm, " mem_a"}, bus.MEM_A, 0);
        check({nm, " mem_wd"}, bus.MEM_WD, 0);
        check({nm, " hit_cnt"}, bus.HIT_CNT, 0);
        check({nm, " miss_cnt"}, bus.MISS_CNT, 0);
        check({nm, " rd"}, bus.RD, 0);
    endtask

    typedef struct {
        bit we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_rd;
        bit exp_hit;
    } vec_t;

    initial begin
        vec_t vec [8];
        logic [DW-1:0] rd;
        bit h;
        int p0;
        vec[0] = '{0, 10'h004, 32'h0, 32'h0000_00FB, 0};
        vec[1] = '{0, 10'h005, 32'h0, 32'h0000_00FA, 1};
        vec[2] = '{1, 10'h005, 32'hDEAD_BEEF, 32'h0, 0};
        vec[3] = '{0, 10'h005, 32'h0, 32'hDEAD_BEEF, 1};
        vec[4] = '{1, 10'h200, 32'h1234_5678, 32'h0, 0};
        vec[5] = '{0, 10'h200, 32'h0, 32'h1234_5678, 0};
        vec[6] = '{0, 10'h084, 32'h0, 32'h0000_007B, 0};
        vec[7] = '{0, 10'h004, 32'h0, 32'h0000_00FB, 0};
        RST = 1'b1;
        bus.A = '0;
        bus.WD = '0;
        bus.RE = 1'b0;
        bus.WE = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        foreach (vec[i]) begin
            do_op(vec[i].we, vec[i].a, vec[i].wd, $sformatf("vec%0d", i), rd, h);
            check($sformatf("vec%0d hit", i), h, vec[i].exp_hit);
            if (!vec[i].we) check($sformatf("vec%0d rd_const", i), rd, vec[i].exp_rd);
        end

        // reset in the third refill cycle, then the same read must refill from scratch
        bus.A = 10'h010;
        bus.RE = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        check("midrefill stall", bus.STALL, 1);
        check("midrefill mem_a", bus.MEM_A, 10'h011);
        bus.RE = 1'b0;
        RST = 1'b1;
        #1;
        check_reset_outputs("midrefill_rst");
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        #1;
        do_op(0, 10'h010, 32'h0, "refetch", rd, h);
        check("refetch hit", h, 0);

        // reset while the write pulse is high drops MEM_WE at once
        p0 = pulse_total;
        bus.A = 10'h020;
        bus.WD = 32'hCAFE_F00D;
        bus.WE = 1'b1;
        @(negedge CLK);
        #1;
        check("midwrite mem_we", bus.MEM_WE, 1);
        bus.WE = 1'b0;
        RST = 1'b1;
        #1;
        check("midwrite_rst mem_we", bus.MEM_WE, 0);
        check("midwrite_rst stall", bus.STALL, 0);
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("midwrite no pulse", pulse_total - p0, 0);

        repeat (150) begin
            bit we = ($urandom % 4) == 0;
            logic [AW-1:0] a = AW'(($urandom % 8) * 128 + ($urandom % 4) * 4 + $urandom % 4);
            do_op(we, a, $urandom, "rand", rd, h);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
